// File: rtl/chunked_seq_adder_pkg.sv
// Shared types for the chunked sequential adder: FSM encoding and add/sub mode codes.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } add_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunked_seq_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder, zero latency; no handshake.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cin_msb
);

  always_comb begin
    logic [CHUNK:0] c;
    c       = '0;
    sum     = '0;
    c[0]    = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout    = c[CHUNK];
    cin_msb = c[CHUNK-1];
  end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/sub, CHUNK bits per cycle; out_valid rises NCHUNK edges after accept.
// Result is held while out_valid && !out_ready; no new operation accepted until handshake.
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  add_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk, c_msb;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_chunk),
    .b       (b_chunk),
    .cin     (carry_q),
    .sum     (s_chunk),
    .cout    (c_chunk),
    .cin_msb (c_msb)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction is a + ~b + 1, so the operand is inverted once at accept.
          a_d        = a;
          b_d        = (sub == MODE_ADD) ? b : ~b;
          carry_d    = (sub == MODE_SUB) ? 1'b1 : cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Carry into MSB differing from carry out is the same as sign-mismatch overflow.
          cout_d      = c_chunk;
          ovf_d       = c_chunk ^ c_msb;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder in three shapes: 8/4, 32/8 and 32/32.
module tb_chunked_seq_adder;

  logic        clk;
  logic        reset;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;
  logic [31:0] a, b;
  logic        cin, sub, out_ready;
  logic [7:0]  sum0;
  logic [31:0] sum1, sum2;

  int n_cmp = 0;
  int n_bad = 0;

  chunked_seq_adder #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  chunked_seq_adder #(.WIDTH(32), .CHUNK(32)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_sum(input int s);
    case (s)
      0:       return {24'h0, sum0};
      1:       return sum1;
      default: return sum2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the handshake edge.
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb, input logic [31:0] es,
                        input logic ec, input logic eo, input int lat_exp, input string tag);
    int lat;
    a = av; b = bv; cin = ci; sub = sb; out_ready = 1'b1;
    chk({tag, ".in_ready"}, {31'h0, in_ready_w[s]}, 32'h1);
    in_valid[s] = 1'b1;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    a = ~av; b = ~bv; cin = ~ci; sub = ~sb;
    lat = 0;
    while (!out_valid_w[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, lat_exp);
    chk({tag, ".sum"},  rd_sum(s), es);
    chk({tag, ".cout"}, {31'h0, cout_w[s]}, {31'h0, ec});
    chk({tag, ".ovf"},  {31'h0, ovf_w[s]},  {31'h0, eo});
    @(posedge clk); #1;
    chk({tag, ".out_valid_after"}, {31'h0, out_valid_w[s]}, 32'h0);
    chk({tag, ".in_ready_after"},  {31'h0, in_ready_w[s]},  32'h1);
  endtask

  initial begin
    int lat;
    int hits;
    reset = 1'b1; in_valid = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset.in_ready",  {29'h0, in_ready_w},  32'h7);
    chk("reset.out_valid", {29'h0, out_valid_w}, 32'h0);
    chk("reset.sum0",      rd_sum(0), 32'h0);
    chk("reset.sum1",      rd_sum(1), 32'h0);
    chk("reset.cout",      {29'h0, cout_w}, 32'h0);
    chk("reset.ovf",       {29'h0, ovf_w},  32'h0);

    // 8-bit, two chunks of 4
    run_op(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 32'h4B, 1'b0, 1'b0, 2, "w8.add_basic");
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 2, "w8.add_wrap");
    run_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 2, "w8.add_ovf");
    run_op(0, 32'h0F, 32'h00, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 2, "w8.add_cin");
    run_op(0, 32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, 2, "w8.sub_borrow");
    run_op(0, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 2, "w8.sub_ovf");
    run_op(0, 32'h10, 32'h01, 1'b1, 1'b1, 32'h0F, 1'b1, 1'b0, 2, "w8.sub_cin_ignored");

    // 32-bit, four chunks of 8
    run_op(1, 32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 4, "w32c8.add_basic");
    run_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4, "w32c8.add_wrap");
    run_op(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 4, "w32c8.add_ovf");
    run_op(1, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4, "w32c8.sub_borrow");
    run_op(1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 4, "w32c8.sub_ovf");

    // 32-bit, single chunk
    run_op(2, 32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1, "w32c32.add_cin");
    run_op(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1, "w32c32.add_wrap");
    run_op(2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1, "w32c32.add_ovf");
    run_op(2, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1, "w32c32.sub_borrow");
    run_op(2, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1, "w32c32.sub_ovf");

    // Backpressure on the 8-bit instance
    a = 32'h3C; b = 32'h0F; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid_w[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid_held", {31'h0, out_valid_w[0]}, 32'h1);
      chk("bp.sum_held",       rd_sum(0), 32'h4B);
      chk("bp.in_ready_low",   {31'h0, in_ready_w[0]}, 32'h0);
      in_valid[0] = ((i % 2) == 0);
      a = 32'h11 * (i + 1); b = 32'h22;
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    chk("bp.sum_before_release", rd_sum(0), 32'h4B);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.out_valid_dropped", {31'h0, out_valid_w[0]}, 32'h0);
    chk("bp.in_ready_back",     {31'h0, in_ready_w[0]},  32'h1);
    chk("bp.sum_kept",          rd_sum(0), 32'h4B);
    hits = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) hits++;
    end
    chk("bp.no_extra_op", hits, 0);

    // Reset in the middle of BUSY on the four-chunk instance
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy.in_ready",  {31'h0, in_ready_w[1]},  32'h1);
    chk("rst_busy.out_valid", {31'h0, out_valid_w[1]}, 32'h0);
    chk("rst_busy.sum",       rd_sum(1), 32'h0);
    chk("rst_busy.cout",      {31'h0, cout_w[1]}, 32'h0);
    chk("rst_busy.ovf",       {31'h0, ovf_w[1]},  32'h0);
    hits = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid_w[1]) hits++;
    end
    chk("rst_busy.never_valid", hits, 0);

    // Reset and in_valid together: nothing may be accepted
    a = 32'h01; b = 32'h02;
    in_valid[0] = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    reset = 1'b0;
    chk("rst_inv.in_ready", {31'h0, in_ready_w[0]}, 32'h1);
    hits = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid_w[0] || !in_ready_w[0]) hits++;
    end
    chk("rst_inv.not_accepted", hits, 0);

    // Normal operation after the aborted one
    run_op(1, 32'h00000100, 32'h000000FF, 1'b1, 1'b0, 32'h00000200, 1'b0, 1'b0, 4, "w32c8.after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
